// File: rtl/proto_checker_mc.sv
// Passive req/gnt handshake monitor for NUM_CH channels plus a counter-step checker.
// Optional feature macro: PROTO_CHK_MSG_EN (simulation-only violation messages).
module proto_checker_mc #(
  parameter int NUM_CH    = 4,
  parameter int MAX_LAT   = 8,
  parameter int CNT_W     = 16,
  parameter int CNT_STEP  = 1,
  parameter int ERR_CNT_W = 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH-1:0]    gnt,
  input  logic [CNT_W-1:0]     count,
  input  logic                 count_vld,
  input  logic                 clr_err,
  output logic [NUM_CH-1:0]    err_proto,
  output logic [NUM_CH-1:0]    err_timeout,
  output logic                 err_count,
  output logic [ERR_CNT_W-1:0] err_total,
  output logic [CH_W-1:0]      first_err_ch,
  output logic                 first_err_vld,
  output logic                 any_err
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, DROP} ch_state_t;

  ch_state_t        state_q [NUM_CH];
  ch_state_t        state_d [NUM_CH];
  logic [LAT_W-1:0] lat_q   [NUM_CH];
  logic [LAT_W-1:0] lat_d   [NUM_CH];

  logic [NUM_CH-1:0]    proto_v, tmo_v, ch_v;
  logic                 cnt_v, any_v;
  logic [CNT_W-1:0]     prev_count, exp_count;
  logic                 prev_vld;

  logic [NUM_CH-1:0]    proto_n, tmo_n;
  logic                 cnt_n, first_vld_base;
  logic [ERR_CNT_W-1:0] total_base, total_n;
  logic [CH_W-1:0]      first_idx;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      lat_d[i]   = lat_q[i];
      proto_v[i] = 1'b0;
      tmo_v[i]   = 1'b0;
      case (state_q[i])
        IDLE: begin
          proto_v[i] = gnt[i];
          if (req[i]) begin
            state_d[i] = WAIT_GNT;
            lat_d[i]   = LAT_W'(1);
          end
        end
        WAIT_GNT: begin
          proto_v[i] = req[i];
          if (gnt[i]) begin
            state_d[i] = DROP;
          end else if (lat_q[i] == LAT_W'(MAX_LAT)) begin
            tmo_v[i]   = 1'b1;
            state_d[i] = IDLE;
          end else begin
            lat_d[i] = lat_q[i] + LAT_W'(1);
          end
        end
        DROP: begin
          proto_v[i] = req[i] | gnt[i];
          state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        lat_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
      end
    end
  end

  assign exp_count = prev_count + CNT_W'(CNT_STEP);
  assign cnt_v     = count_vld && prev_vld && (count != exp_count);
  assign ch_v      = proto_v | tmo_v;
  assign any_v     = (|ch_v) | cnt_v;

  // Clear is applied first so a violation in the clear cycle is still recorded.
  always_comb begin
    proto_n        = (clr_err ? '0 : err_proto) | proto_v;
    tmo_n          = (clr_err ? '0 : err_timeout) | tmo_v;
    cnt_n          = (clr_err ? 1'b0 : err_count) | cnt_v;
    total_base     = clr_err ? '0 : err_total;
    total_n        = (any_v && total_base != '1) ? total_base + ERR_CNT_W'(1) : total_base;
    first_vld_base = clr_err ? 1'b0 : first_err_vld;
    first_idx      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_v[i]) first_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_proto     <= '0;
      err_timeout   <= '0;
      err_count     <= 1'b0;
      err_total     <= '0;
      first_err_ch  <= '0;
      first_err_vld <= 1'b0;
      any_err       <= 1'b0;
      prev_count    <= '0;
      prev_vld      <= 1'b0;
    end else begin
      err_proto     <= proto_n;
      err_timeout   <= tmo_n;
      err_count     <= cnt_n;
      err_total     <= total_n;
      first_err_vld <= first_vld_base | (|ch_v);
      if (!first_vld_base && (|ch_v)) first_err_ch <= first_idx;
      any_err       <= (|proto_n) | (|tmo_n) | cnt_n;
      prev_vld      <= count_vld;
      if (count_vld) prev_count <= count;
    end
  end

`ifdef PROTO_CHK_MSG_EN
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (proto_v[i]) $display("%0t proto_checker_mc: ch %0d PROTO violation", $time, i);
        if (tmo_v[i])   $display("%0t proto_checker_mc: ch %0d TIMEOUT violation", $time, i);
      end
      if (cnt_v) $display("%0t proto_checker_mc: count step violation, expected %0h actual %0h",
                          $time, exp_count, count);
    end
  end
`endif
`else
  // Messages disabled; checker behaviour is unchanged.
`endif

endmodule
